// File: rtl/key_cmd_queue.sv
// Key-press command queue: edge-detects four direction keys and queues the winning press as a 2-bit code in a small FIFO.
// Optional feature: define KEY_CMD_DROP_DUP_EN to discard a press that repeats the newest entry still queued.
module key_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_up,
    input  logic                     key_down,
    input  logic                     key_left,
    input  logic                     key_right,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic                     cmd_valid,
    output logic [1:0]               cmd_code,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [3:0]    w_keys;
    logic [3:0]    w_rise;
    logic          w_evt;
    logic [1:0]    w_evtCode;
    logic          w_dup;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_write;
    logic          w_ovfSet;
    logic [AW-1:0] w_lastPtr;

    logic [3:0]    r_keyPrev;
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [1:0]    r_mem [DEPTH];

    assign w_keys    = {key_right, key_left, key_down, key_up};
    assign w_rise    = w_keys & ~r_keyPrev;
    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_lastPtr = r_wrPtr - AW'(1);

    // Fixed priority up > down > left > right; losing presses are simply dropped.
    always_comb begin
        w_evt     = 1'b0;
        w_evtCode = 2'b00;
        if (w_rise[0]) begin
            w_evt     = 1'b1;
            w_evtCode = 2'b00;
        end else if (w_rise[1]) begin
            w_evt     = 1'b1;
            w_evtCode = 2'b01;
        end else if (w_rise[2]) begin
            w_evt     = 1'b1;
            w_evtCode = 2'b10;
        end else if (w_rise[3]) begin
            w_evt     = 1'b1;
            w_evtCode = 2'b11;
        end
    end

`ifdef KEY_CMD_DROP_DUP_EN
    assign w_dup = !w_empty && (r_mem[w_lastPtr] == w_evtCode);
`else
    assign w_dup = 1'b0;
`endif

    // A pop frees the head slot, so a push into a full queue still lands when paired with a pop.
    assign w_push   = w_evt & ~w_dup;
    assign w_pop    = pop & ~w_empty;
    assign w_write  = w_push & (~w_full | w_pop);
    assign w_ovfSet = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keyPrev  <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_keyPrev <= w_keys;
            if (w_write) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovfSet) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only visible through the reset-cleared count and pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_wrPtr] <= w_evtCode;
        end
    end

    assign cmd_valid = ~w_empty;
    assign cmd_code  = cmd_valid ? r_mem[r_rdPtr] : 2'b00;
    assign cmd_count = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue (DEPTH=4); duplicate-drop expectations follow KEY_CMD_DROP_DUP_EN.
module tb_key_cmd_queue;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] keys;
        logic       pop;
        logic       ovfClr;
        logic       expValid;
        logic [1:0] expCode;
        logic [2:0] expCount;
        logic       expOvf;
    } vec_t;

`ifdef KEY_CMD_DROP_DUP_EN
    localparam logic [2:0] DUP_COUNT = 3'd1;
`else
    localparam logic [2:0] DUP_COUNT = 3'd2;
`endif

    logic       clk;
    logic       rst;
    logic       keyUp, keyDown, keyLeft, keyRight;
    logic       pop;
    logic       ovfClr;
    logic       cmdValid;
    logic [1:0] cmdCode;
    logic [2:0] cmdCount;
    logic       overflow;

    int testsRun;
    int testsFailed;
    vec_t vecs[$];

    key_cmd_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up    (keyUp),
        .key_down  (keyDown),
        .key_left  (keyLeft),
        .key_right (keyRight),
        .pop       (pop),
        .ovf_clr   (ovfClr),
        .cmd_valid (cmdValid),
        .cmd_code  (cmdCode),
        .cmd_count (cmdCount),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keys are {right, left, down, up}
    function automatic void addVec(input string name, input logic r, input logic [3:0] k,
                                   input logic p, input logic oc, input logic ev,
                                   input logic [1:0] ec, input logic [2:0] en, input logic eo);
        vec_t v;
        v.name = name; v.rst = r; v.keys = k; v.pop = p; v.ovfClr = oc;
        v.expValid = ev; v.expCode = ec; v.expCount = en; v.expOvf = eo;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then let the edge happen and settle.
    task automatic applyStimulus(input logic r, input logic [3:0] k, input logic p, input logic oc);
        rst      = r;
        keyUp    = k[0];
        keyDown  = k[1];
        keyLeft  = k[2];
        keyRight = k[3];
        pop      = p;
        ovfClr   = oc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [1:0] ec,
                               input logic [2:0] en, input logic eo);
        testsRun++;
        if (cmdValid !== ev || cmdCode !== ec || cmdCount !== en || overflow !== eo) begin
            testsFailed++;
            $display("[TB] FAIL %s: got valid=%0b code=%0d count=%0d ovf=%0b, expected valid=%0b code=%0d count=%0d ovf=%0b",
                     name, cmdValid, cmdCode, cmdCount, overflow, ev, ec, en, eo);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst = 1'b1; keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
        pop = 1'b0; ovfClr = 1'b0;

        addVec("reset0",        1, 4'b0000, 0, 0, 0, 2'd0, 3'd0, 0);
        addVec("reset1",        1, 4'b0000, 0, 0, 0, 2'd0, 3'd0, 0);
        addVec("leftPulse",     0, 4'b0100, 0, 0, 1, 2'd2, 3'd1, 0);
        addVec("leftIdle",      0, 4'b0000, 0, 0, 1, 2'd2, 3'd1, 0);
        addVec("leftPop",       0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 0);
        addVec("upRightSame",   0, 4'b1001, 0, 0, 1, 2'd0, 3'd1, 0);
        addVec("upRightPop",    0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 0);
        addVec("fillUp",        0, 4'b0001, 0, 0, 1, 2'd0, 3'd1, 0);
        addVec("fillDown",      0, 4'b0010, 0, 0, 1, 2'd0, 3'd2, 0);
        addVec("fillLeft",      0, 4'b0100, 0, 0, 1, 2'd0, 3'd3, 0);
        addVec("fillRight",     0, 4'b1000, 0, 0, 1, 2'd0, 3'd4, 0);
        addVec("fullDrop",      0, 4'b0001, 0, 0, 1, 2'd0, 3'd4, 1);
        addVec("drain1",        0, 4'b0000, 1, 0, 1, 2'd1, 3'd3, 1);
        addVec("drain2",        0, 4'b0000, 1, 0, 1, 2'd2, 3'd2, 1);
        addVec("drain3",        0, 4'b0000, 1, 0, 1, 2'd3, 3'd1, 1);
        addVec("drain4",        0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 1);
        addVec("popEmpty",      0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 1);
        addVec("ovfClear",      0, 4'b0000, 0, 1, 0, 2'd0, 3'd0, 0);
        addVec("refillUp",      0, 4'b0001, 0, 0, 1, 2'd0, 3'd1, 0);
        addVec("refillDown",    0, 4'b0010, 0, 0, 1, 2'd0, 3'd2, 0);
        addVec("refillLeft",    0, 4'b0100, 0, 0, 1, 2'd0, 3'd3, 0);
        addVec("refillRight",   0, 4'b1000, 0, 0, 1, 2'd0, 3'd4, 0);
        addVec("ovfSetWins",    0, 4'b0001, 0, 1, 1, 2'd0, 3'd4, 1);
        addVec("ovfClear2",     0, 4'b0000, 0, 1, 1, 2'd0, 3'd4, 0);
        addVec("fullPushPop",   0, 4'b0010, 1, 0, 1, 2'd1, 3'd4, 0);
        addVec("fpDrain1",      0, 4'b0000, 1, 0, 1, 2'd2, 3'd3, 0);
        addVec("fpDrain2",      0, 4'b0000, 1, 0, 1, 2'd3, 3'd2, 0);
        addVec("fpDrainLast",   0, 4'b0000, 1, 0, 1, 2'd1, 3'd1, 0);
        addVec("fpEmpty",       0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 0);
        for (int i = 0; i < 10; i++) begin
            addVec($sformatf("holdRight%0d", i), 0, 4'b1000, 0, 0, 1, 2'd3, 3'd1, 0);
        end
        addVec("holdRelease",   0, 4'b0000, 0, 0, 1, 2'd3, 3'd1, 0);
        addVec("holdPop",       0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 0);
        addVec("underflow",     0, 4'b0000, 1, 0, 0, 2'd0, 3'd0, 0);
        addVec("dupFirst",      0, 4'b0001, 0, 0, 1, 2'd0, 3'd1, 0);
        for (int i = 0; i < 4; i++) begin
            addVec($sformatf("dupGap%0d", i), 0, 4'b0000, 0, 0, 1, 2'd0, 3'd1, 0);
        end
        addVec("dupSecond",     0, 4'b0001, 0, 0, 1, 2'd0, DUP_COUNT, 0);
        addVec("dupSettle",     0, 4'b0000, 0, 0, 1, 2'd0, DUP_COUNT, 0);
        addVec("midReset0",     1, 4'b0100, 1, 1, 0, 2'd0, 3'd0, 0);
        addVec("midReset1",     1, 4'b0100, 1, 0, 0, 2'd0, 3'd0, 0);
        addVec("heldRelease",   0, 4'b0100, 0, 0, 1, 2'd2, 3'd1, 0);
        addVec("heldStill",     0, 4'b0100, 0, 0, 1, 2'd2, 3'd1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].keys, vecs[i].pop, vecs[i].ovfClr);
            checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expCode,
                        vecs[i].expCount, vecs[i].expOvf);
        end

        // Three-way tie, then a later two-way tie: down wins, then left wins.
        applyStimulus(1, 4'b0000, 0, 0);
        checkOutput("prioReset", 0, 2'd0, 3'd0, 0);
        applyStimulus(0, 4'b1110, 0, 0);
        checkOutput("prioDown", 1, 2'd1, 3'd1, 0);
        applyStimulus(0, 4'b0000, 0, 0);
        applyStimulus(0, 4'b1100, 0, 0);
        checkOutput("prioLeftQueued", 1, 2'd1, 3'd2, 0);
        applyStimulus(0, 4'b0000, 1, 0);
        checkOutput("prioLeftHead", 1, 2'd2, 3'd1, 0);
        applyStimulus(0, 4'b0000, 1, 0);
        checkOutput("prioEmpty", 0, 2'd0, 3'd0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
